// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and FSM-state definitions for the ALU register engine.
// Also provides the flag-packing helper used by every Y-writing path.
package alu_pkg;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_CMP  = 5'd2;
    localparam logic [4:0] OP_SHL  = 5'd3;
    localparam logic [4:0] OP_SHR  = 5'd4;
    localparam logic [4:0] OP_AND  = 5'd5;
    localparam logic [4:0] OP_OR   = 5'd6;
    localparam logic [4:0] OP_XOR  = 5'd7;
    localparam logic [4:0] OP_NAND = 5'd8;
    localparam logic [4:0] OP_NOR  = 5'd9;
    localparam logic [4:0] OP_XNOR = 5'd10;
    localparam logic [4:0] OP_INV  = 5'd11;
    localparam logic [4:0] OP_NEG  = 5'd12;
    localparam logic [4:0] OP_STO  = 5'd13;
    localparam logic [4:0] OP_SWP  = 5'd14;
    localparam logic [4:0] OP_LOAD = 5'd15;
    localparam logic [4:0] OP_MUL  = 5'd16;

    localparam int FLG_Z = 0;
    localparam int FLG_C = 1;
    localparam int FLG_N = 2;
    localparam int FLG_V = 3;

    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_MUL_RUN = 1'b1;

    function automatic logic [3:0] packFlags(input logic v, input logic n, input logic c, input logic z);
        logic [3:0] f;
        f        = 4'b0000;
        f[FLG_V] = v;
        f[FLG_N] = n;
        f[FLG_C] = c;
        f[FLG_Z] = z;
        return f;
    endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Unsigned shift-add multiplier, one partial product per cycle, WIDTH cycles per product.
// Only instantiated when ALU_REG_ENGINE_MUL_EN is defined.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   mcandIn,
    input  logic [WIDTH-1:0]   mplierIn,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] acc_r;
    logic [2*WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0]   mplier_r;
    logic [CW-1:0]      count_r;
    logic               run_r;

    // Next accumulator value; on the final step this is the finished product
    always_comb begin
        product = acc_r + (mplier_r[0] ? mcand_r : {(2*WIDTH){1'b0}});
        done    = run_r && (count_r == CW'(1));
    end

    assign busy = run_r;

    // Shift-add iteration
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_r    <= {(2*WIDTH){1'b0}};
            mcand_r  <= {(2*WIDTH){1'b0}};
            mplier_r <= {WIDTH{1'b0}};
            count_r  <= {CW{1'b0}};
            run_r    <= 1'b0;
        end else if (start) begin
            acc_r    <= {(2*WIDTH){1'b0}};
            mcand_r  <= {{WIDTH{1'b0}}, mcandIn};
            mplier_r <= mplierIn;
            count_r  <= CW'(WIDTH);
            run_r    <= 1'b1;
        end else if (run_r) begin
            acc_r    <= product;
            mcand_r  <= mcand_r << 1;
            mplier_r <= mplier_r >> 1;
            count_r  <= count_r - CW'(1);
            if (done) begin
                run_r <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_reg_engine.sv
// A/B/Y register engine: one opcode per accepted exec strobe, with flags and done/err status.
// Optional multi-cycle MUL enabled by defining ALU_REG_ENGINE_MUL_EN.
module alu_reg_engine
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int OPW   = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             exec,
    input  logic [OPW-1:0]   op,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic [3:0]       flags,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

    logic [WIDTH-1:0] aReg_r, bReg_r, yReg_r;
    logic [3:0]       flags_r;
    logic             done_r, err_r;

    logic [WIDTH:0]   sum_s, diff_s, shl_s, shr_s;
    logic [WIDTH-1:0] resY_s;
    logic             resC_s, resV_s, writesY_s, illegal_s, isMul_s, accept_s;

    assign a     = aReg_r;
    assign b     = bReg_r;
    assign y     = yReg_r;
    assign flags = flags_r;
    assign done  = done_r;
    assign err   = err_r;

`ifdef ALU_REG_ENGINE_MUL_EN
    logic [0:0]         state_r;
    logic               mulPend_r, mulStart_s, mulBusy_s, mulDone_s;
    logic [2*WIDTH-1:0] mulProd_s;

    // The engine stays occupied until the edge that raises done for the multiply
    assign accept_s   = exec && (state_r == S_IDLE);
    assign mulStart_s = accept_s && isMul_s;
    assign busy       = mulBusy_s;

    alu_mul_seq #(.WIDTH(WIDTH)) uMul (
        .clock    (clock),
        .reset    (reset),
        .start    (mulStart_s),
        .mcandIn  (aReg_r),
        .mplierIn (bReg_r),
        .busy     (mulBusy_s),
        .done     (mulDone_s),
        .product  (mulProd_s)
    );

    // Sequencing FSM and delayed completion marker for the multiply
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r   <= S_IDLE;
            mulPend_r <= 1'b0;
        end else begin
            mulPend_r <= mulDone_s;
            if (mulStart_s) begin
                state_r <= S_MUL_RUN;
            end else if (mulPend_r) begin
                state_r <= S_IDLE;
            end
        end
    end
`else
    assign accept_s = exec;
    assign busy     = 1'b0;
`endif

    // Single-cycle opcode evaluation
    always_comb begin
        sum_s     = {1'b0, aReg_r} + {1'b0, bReg_r};
        diff_s    = {1'b0, aReg_r} - {1'b0, bReg_r};
        shl_s     = {1'b0, aReg_r} << bReg_r;
        shr_s     = {aReg_r, 1'b0} >> bReg_r;
        resY_s    = yReg_r;
        resC_s    = 1'b0;
        resV_s    = 1'b0;
        writesY_s = 1'b1;
        illegal_s = 1'b0;
        isMul_s   = 1'b0;
        case (op)
            OP_ADD: begin
                resY_s = sum_s[WIDTH-1:0];
                resC_s = sum_s[WIDTH];
                resV_s = (aReg_r[WIDTH-1] == bReg_r[WIDTH-1]) && (sum_s[WIDTH-1] != aReg_r[WIDTH-1]);
            end
            OP_SUB: begin
                resY_s = diff_s[WIDTH-1:0];
                resC_s = diff_s[WIDTH];
                resV_s = (aReg_r[WIDTH-1] != bReg_r[WIDTH-1]) && (diff_s[WIDTH-1] != aReg_r[WIDTH-1]);
            end
            OP_CMP: begin
                if (aReg_r > bReg_r) begin
                    resY_s = {{(WIDTH-1){1'b0}}, 1'b1};
                end else if (aReg_r == bReg_r) begin
                    resY_s = {WIDTH{1'b0}};
                end else begin
                    resY_s = {WIDTH{1'b1}};
                end
                resC_s = aReg_r < bReg_r;
            end
            // Shift distances of WIDTH or more clear both Y and carry
            OP_SHL: begin
                if (bReg_r >= WIDTH_V) begin
                    resY_s = {WIDTH{1'b0}};
                end else begin
                    resY_s = shl_s[WIDTH-1:0];
                    resC_s = shl_s[WIDTH];
                end
            end
            OP_SHR: begin
                if (bReg_r >= WIDTH_V) begin
                    resY_s = {WIDTH{1'b0}};
                end else begin
                    resY_s = shr_s[WIDTH:1];
                    resC_s = shr_s[0];
                end
            end
            OP_AND:  resY_s = aReg_r & bReg_r;
            OP_OR:   resY_s = aReg_r | bReg_r;
            OP_XOR:  resY_s = aReg_r ^ bReg_r;
            OP_NAND: resY_s = ~(aReg_r & bReg_r);
            OP_NOR:  resY_s = ~(aReg_r | bReg_r);
            OP_XNOR: resY_s = ~(aReg_r ^ bReg_r);
            OP_INV:  resY_s = ~aReg_r;
            OP_NEG: begin
                resY_s = {WIDTH{1'b0}} - aReg_r;
                resC_s = |aReg_r;
                resV_s = aReg_r == {1'b1, {(WIDTH-1){1'b0}}};
            end
            OP_STO, OP_SWP, OP_LOAD: writesY_s = 1'b0;
`ifdef ALU_REG_ENGINE_MUL_EN
            OP_MUL: begin
                writesY_s = 1'b0;
                isMul_s   = 1'b1;
            end
`endif
            default: begin
                writesY_s = 1'b0;
                illegal_s = 1'b1;
            end
        endcase
    end

    // Architectural registers, done pulse and sticky error flag
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            aReg_r  <= {WIDTH{1'b0}};
            bReg_r  <= {WIDTH{1'b0}};
            yReg_r  <= {WIDTH{1'b0}};
            flags_r <= 4'b0000;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (exec && !accept_s) begin
                err_r <= 1'b1;
            end else if (accept_s && !isMul_s) begin
                done_r <= 1'b1;
                if (illegal_s) begin
                    err_r <= 1'b1;
                end else if (writesY_s) begin
                    yReg_r  <= resY_s;
                    flags_r <= packFlags(resV_s, resY_s[WIDTH-1], resC_s, resY_s == {WIDTH{1'b0}});
                end else begin
                    case (op)
                        OP_STO:  bReg_r <= aReg_r;
                        OP_SWP: begin
                            aReg_r <= bReg_r;
                            bReg_r <= aReg_r;
                        end
                        OP_LOAD: aReg_r <= din;
                        default: ;
                    endcase
                end
            end
`ifdef ALU_REG_ENGINE_MUL_EN
            if (mulDone_s) begin
                yReg_r  <= mulProd_s[WIDTH-1:0];
                flags_r <= packFlags(1'b0, mulProd_s[WIDTH-1], |mulProd_s[2*WIDTH-1:WIDTH],
                                     mulProd_s[WIDTH-1:0] == {WIDTH{1'b0}});
            end
            if (mulPend_r) begin
                done_r <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_alu_reg_engine.sv
// Self-checking bench for alu_reg_engine: directed literal checks plus randomized traffic
// compared every cycle against an arithmetic reference model.
module tb_alu_reg_engine;

    localparam int     W   = 8;
    localparam longint MOD = longint'(1) << W;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         exec  = 1'b0;
    logic [4:0]   op    = 5'd0;
    logic [W-1:0] din   = {W{1'b0}};
    logic [W-1:0] a, b, y;
    logic [3:0]   flags;
    logic         busy, done, err;

    int tests = 0;
    int fails = 0;
    bit checkEn = 1'b0;

    logic [W-1:0] mA, mB, mY;
    logic [3:0]   mFlags;
    logic         mBusy, mDone, mErr;
    int           mulAge = -1;

    alu_reg_engine #(.WIDTH(W), .OPW(5)) dut (
        .clock(clock), .reset(reset), .exec(exec), .op(op), .din(din),
        .a(a), .b(b), .y(y), .flags(flags), .busy(busy), .done(done), .err(err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input longint got, input longint exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    function automatic longint sval(input longint x);
        return (x >= MOD / 2) ? x - MOD : x;
    endfunction

    function automatic bit ovf(input longint s);
        return (s > MOD / 2 - 1) || (s < -(MOD / 2));
    endfunction

    task automatic setY(input longint yv, input bit c, input bit v);
        mY     = W'(yv);
        mFlags = {v, yv >= MOD / 2, c, yv == 0};
    endtask

    task automatic modelReset();
        mA = '0; mB = '0; mY = '0; mFlags = 4'b0000;
        mBusy = 1'b0; mDone = 1'b0; mErr = 1'b0; mulAge = -1;
    endtask

    // Reference behaviour for one rising edge with the given request inputs
    task automatic modelEdge(input bit ex, input logic [4:0] o, input logic [W-1:0] d);
        longint A, B, r;
        logic [W-1:0] t;
        A = longint'(mA);
        B = longint'(mB);
        mDone = 1'b0;
        if (mulAge >= 0) begin
            if (ex) mErr = 1'b1;
            mulAge++;
            if (mulAge == W) begin
                r = A * B;
                setY(r % MOD, (r / MOD) != 0, 1'b0);
                mBusy = 1'b0;
            end else if (mulAge == W + 1) begin
                mDone  = 1'b1;
                mulAge = -1;
            end
        end else if (ex) begin
            mDone = 1'b1;
            case (o)
                5'd0: begin r = A + B; setY(r % MOD, r >= MOD, ovf(sval(A) + sval(B))); end
                5'd1: begin r = A - B; setY((r + MOD) % MOD, A < B, ovf(sval(A) - sval(B))); end
                5'd2: setY((A > B) ? 1 : ((A == B) ? 0 : MOD - 1), A < B, 1'b0);
                5'd3: begin
                    if (B == 0) setY(A, 1'b0, 1'b0);
                    else if (B >= W) setY(0, 1'b0, 1'b0);
                    else setY((A << B) % MOD, ((A >> (W - B)) & 1) != 0, 1'b0);
                end
                5'd4: begin
                    if (B == 0) setY(A, 1'b0, 1'b0);
                    else if (B >= W) setY(0, 1'b0, 1'b0);
                    else setY(A >> B, ((A >> (B - 1)) & 1) != 0, 1'b0);
                end
                5'd5:  setY(A & B, 1'b0, 1'b0);
                5'd6:  setY(A | B, 1'b0, 1'b0);
                5'd7:  setY(A ^ B, 1'b0, 1'b0);
                5'd8:  setY((MOD - 1) - (A & B), 1'b0, 1'b0);
                5'd9:  setY((MOD - 1) - (A | B), 1'b0, 1'b0);
                5'd10: setY((MOD - 1) - (A ^ B), 1'b0, 1'b0);
                5'd11: setY((MOD - 1) - A, 1'b0, 1'b0);
                5'd12: setY((MOD - A) % MOD, A != 0, A == MOD / 2);
                5'd13: mB = mA;
                5'd14: begin t = mA; mA = mB; mB = t; end
                5'd15: mA = d;
`ifdef ALU_REG_ENGINE_MUL_EN
                5'd16: begin mDone = 1'b0; mulAge = 0; mBusy = 1'b1; end
`endif
                default: mErr = 1'b1;
            endcase
        end
    endtask

    // Per-cycle comparison of every output against the model
    always @(negedge clock) begin
        if (checkEn) begin
            chk("a", a, mA);
            chk("b", b, mB);
            chk("y", y, mY);
            chk("flags", flags, mFlags);
            chk("busy", busy, mBusy);
            chk("done", done, mDone);
            chk("err", err, mErr);
        end
    end

    task automatic doCycle(input bit ex, input logic [4:0] o, input logic [W-1:0] d);
        exec = ex; op = o; din = d;
        @(posedge clock);
        if (!reset) modelEdge(ex, o, d);
        @(negedge clock);
        exec = 1'b0;
    endtask

    task automatic loadAB(input logic [W-1:0] av, input logic [W-1:0] bv);
        doCycle(1'b1, 5'd15, bv);
        doCycle(1'b1, 5'd13, {W{1'b0}});
        doCycle(1'b1, 5'd15, av);
    endtask

    task automatic resetPulse(input int cycles);
        #2 reset = 1'b1;
        modelReset();
        repeat (cycles) @(posedge clock);
        @(negedge clock);
        #2 reset = 1'b0;
    endtask

    initial begin
        int busyCnt, lastBusy, doneIdx, doneSeen;
        bit ex;
        logic [4:0] o;
        logic [W-1:0] d;

        modelReset();
        #3 reset = 1'b1;
        checkEn = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_a", a, 0); chk("rst_b", b, 0); chk("rst_y", y, 0);
        chk("rst_flags", flags, 0); chk("rst_err", err, 0);
        #2 reset = 1'b0;

        doCycle(1'b1, 5'd15, 8'h7F); chk("load_done", done, 1);
        doCycle(1'b1, 5'd13, 8'h00); chk("sto_done", done, 1);
        doCycle(1'b1, 5'd15, 8'h01); chk("load2_done", done, 1);
        chk("lsl_a", a, 8'h01); chk("lsl_b", b, 8'h7F);
        doCycle(1'b0, 5'd0, 8'h00); chk("idle_done", done, 0);

        loadAB(8'h7F, 8'h01); doCycle(1'b1, 5'd0, 8'h00);
        chk("add_y", y, 8'h80); chk("add_flags", flags, 4'b1100);
        loadAB(8'h01, 8'h02); doCycle(1'b1, 5'd1, 8'h00);
        chk("sub_y", y, 8'hFF); chk("sub_c", flags[1], 1);
        loadAB(8'h81, 8'h03); doCycle(1'b1, 5'd3, 8'h00);
        chk("shl_y", y, 8'h08); chk("shl_c", flags[1], 0);
        doCycle(1'b1, 5'd4, 8'h00);
        chk("shr_y", y, 8'h10); chk("shr_c", flags[1], 0);
        loadAB(8'h81, 8'h09); doCycle(1'b1, 5'd3, 8'h00);
        chk("shl9_y", y, 8'h00); chk("shl9_flags", flags, 4'b0001);
        loadAB(8'h05, 8'h05); doCycle(1'b1, 5'd2, 8'h00);
        chk("cmp_y", y, 8'h00); chk("cmp_z", flags[0], 1);
        loadAB(8'h12, 8'h34); doCycle(1'b1, 5'd14, 8'h00);
        chk("swp_a", a, 8'h34); chk("swp_b", b, 8'h12); chk("swp_y", y, 8'h00);
        doCycle(1'b1, 5'd15, 8'h80); doCycle(1'b1, 5'd12, 8'h00);
        chk("neg_y", y, 8'h80); chk("neg_flags", flags, 4'b1110);
        doCycle(1'b1, 5'd20, 8'h00);
        chk("ill_err", err, 1); chk("ill_done", done, 1);
        chk("ill_a", a, 8'h80); chk("ill_b", b, 8'h12); chk("ill_y", y, 8'h80);

`ifdef ALU_REG_ENGINE_MUL_EN
        resetPulse(1);
        loadAB(8'h10, 8'h11);
        doCycle(1'b1, 5'd16, 8'h00);
        chk("mul_busy0", busy, 1);
        busyCnt = 1; lastBusy = 0; doneIdx = -1;
        for (int i = 1; i <= 30 && doneIdx < 0; i++) begin
            doCycle(i == 3, 5'd0, 8'h00);
            if (busy) begin busyCnt++; lastBusy = i; end
            if (done) doneIdx = i;
        end
        chk("mul_busy_cycles", busyCnt, 8);
        chk("mul_done_gap", doneIdx - lastBusy, 2);
        chk("mul_y", y, 8'h10); chk("mul_flags", flags, 4'b0010);
        chk("mul_err", err, 1); chk("mul_a", a, 8'h10); chk("mul_b", b, 8'h11);

        resetPulse(1);
        loadAB(8'h10, 8'h11);
        doCycle(1'b1, 5'd16, 8'h00);
        repeat (3) doCycle(1'b0, 5'd0, 8'h00);
        #2 reset = 1'b1;
        modelReset();
        #1 chk("abort_busy", busy, 0); chk("abort_y", y, 0);
        @(negedge clock);
        #2 reset = 1'b0;
        doneSeen = 0;
        repeat (12) begin
            doCycle(1'b0, 5'd0, 8'h00);
            if (done) doneSeen++;
        end
        chk("abort_no_done", doneSeen, 0);
`else
        resetPulse(1);
        doCycle(1'b1, 5'd16, 8'h00);
        chk("mul_off_err", err, 1); chk("mul_off_busy", busy, 0); chk("mul_off_done", done, 1);
`endif

        resetPulse(1);
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                resetPulse(1);
            end else begin
                ex = ($urandom_range(0, 99) < 75);
                o  = ($urandom_range(0, 19) == 0) ? 5'($urandom_range(17, 31)) : 5'($urandom_range(0, 16));
                d  = ($urandom_range(0, 1) == 1) ? W'($urandom_range(0, 9)) : W'($urandom);
                doCycle(ex, o, d);
            end
        end

        checkEn = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
